// File: rtl/regfile_scan_checker.sv
`default_nettype none
// ============================================================================
// regfile_scan_checker: runs the CPU for N cycles, then scans the regfile A
// read port against an expected-value ROM.                         Rev 1.0
// ============================================================================
module regfile_scan_checker #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int CYCLE_W    = 16,
  parameter int ERR_W      = $clog2(NUM_REGS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYCLE_W-1:0]    num_cycles,
  input  logic [NUM_REGS-1:0]   compare_mask,
  output logic                  cpu_run,
  input  logic [REG_ADDR_W-1:0] cpu_rs1,
  output logic [REG_ADDR_W-1:0] rs1_out,
  input  logic [DATA_W-1:0]     reg_data,
  output logic [REG_ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0]     exp_data,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      error_count,
  output logic [REG_ADDR_W-1:0] first_fail_reg,
  output logic                  first_fail_valid,
  output logic [CYCLE_W-1:0]    cycle_count,
  output logic [CYCLE_W-1:0]    write_count
);

  localparam int SCNT_W = $clog2(NUM_REGS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CYCLE_W-1:0]    ncyc_q;
  logic [CYCLE_W-1:0]    cycle_q;
  logic [CYCLE_W-1:0]    wcnt_q;
  logic [NUM_REGS-1:0]   mask_q;
  logic [SCNT_W-1:0]     scnt_q;
  logic                  cmp_vld_q;
  logic [REG_ADDR_W-1:0] cmp_idx_q;
  logic [DATA_W-1:0]     cap_q;
  logic [ERR_W-1:0]      err_q;
  logic [REG_ADDR_W-1:0] ffr_q;
  logic                  ffv_q;

  logic                  accept;
  logic                  issue;
  logic                  mismatch;
  logic [REG_ADDR_W-1:0] scan_idx;

  // Writeback data carries no information for this checker.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cpu_run  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    pass     = 1'b0;
    issue    = 1'b0;
    scan_idx = REG_ADDR_W'(NUM_REGS - 1);
    rs1_out  = cpu_rs1;
    exp_addr = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        pass = (state_q == S_DONE) && (err_q == '0);
        if (start) begin
          accept  = 1'b1;
          state_d = (num_cycles == '0) ? S_SCAN : S_RUN;
        end
      end
      S_RUN: begin
        cpu_run = 1'b1;
        busy    = 1'b1;
        if (cycle_q == ncyc_q - CYCLE_W'(1)) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        busy  = 1'b1;
        issue = (scnt_q < SCNT_W'(NUM_REGS));
        // The drain cycle keeps the last index on the port instead of wrapping.
        if (issue) begin
          scan_idx = REG_ADDR_W'(scnt_q);
          exp_addr = REG_ADDR_W'(scnt_q);
        end
        rs1_out = scan_idx;
        if (scnt_q == SCNT_W'(NUM_REGS)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Captured regfile data meets the ROM word one cycle later, when it arrives.
  assign mismatch = cmp_vld_q && mask_q[cmp_idx_q] && (cap_q != exp_data);

  always_ff @(posedge clock) begin
    if (reset) begin
      ncyc_q    <= '0;
      mask_q    <= '0;
      cycle_q   <= '0;
      wcnt_q    <= '0;
      scnt_q    <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      cap_q     <= '0;
      err_q     <= '0;
      ffr_q     <= '0;
      ffv_q     <= 1'b0;
    end else if (accept) begin
      ncyc_q    <= num_cycles;
      mask_q    <= compare_mask;
      cycle_q   <= '0;
      wcnt_q    <= '0;
      scnt_q    <= '0;
      cmp_vld_q <= 1'b0;
      err_q     <= '0;
      ffr_q     <= '0;
      ffv_q     <= 1'b0;
    end else begin
      if (state_q == S_RUN) begin
        cycle_q <= cycle_q + CYCLE_W'(1);
        if (wb_en && (wb_reg != '0) && (wcnt_q != '1)) begin
          wcnt_q <= wcnt_q + CYCLE_W'(1);
        end
      end
      if (state_q == S_SCAN) begin
        scnt_q <= scnt_q + SCNT_W'(1);
      end
      cmp_vld_q <= issue;
      cmp_idx_q <= scan_idx;
      if (issue) begin
        cap_q <= reg_data;
      end
      if (mismatch) begin
        err_q <= err_q + ERR_W'(1);
        if (!ffv_q) begin
          ffr_q <= cmp_idx_q;
          ffv_q <= 1'b1;
        end
      end
    end
  end

  assign error_count      = err_q;
  assign first_fail_reg   = ffr_q;
  assign first_fail_valid = ffv_q;
  assign cycle_count      = cycle_q;
  assign write_count      = wcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scan_checker.sv
`default_nettype none
// Scoreboard bench for regfile_scan_checker: random regfile/ROM contents,
// masks, run lengths and writeback traffic checked against a run-level model.
module tb_regfile_scan_checker;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int EW = $clog2(NR + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_cycles;
  logic [NR-1:0] compare_mask;
  logic          cpu_run;
  logic [AW-1:0] cpu_rs1;
  logic [AW-1:0] rs1_out;
  logic [DW-1:0] reg_data;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          wb_en;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] error_count;
  logic [AW-1:0] first_fail_reg;
  logic          first_fail_valid;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] write_count;

  regfile_scan_checker #(
    .NUM_REGS(NR), .REG_ADDR_W(AW), .DATA_W(DW), .CYCLE_W(CW), .ERR_W(EW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .compare_mask(compare_mask), .cpu_run(cpu_run), .cpu_rs1(cpu_rs1),
    .rs1_out(rs1_out), .reg_data(reg_data), .exp_addr(exp_addr),
    .exp_data(exp_data), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .first_fail_reg(first_fail_reg), .first_fail_valid(first_fail_valid),
    .cycle_count(cycle_count), .write_count(write_count)
  );

  always #5 clock = ~clock;

  // Environment: combinational regfile read port, synchronous ROM
  logic [DW-1:0] rf  [NR];
  logic [DW-1:0] rom [NR];
  assign reg_data = rf[rs1_out];
  always @(posedge clock) exp_data <= rom[exp_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int start_cyc;
    int n;
    int err;
    int ffr;
    int wc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops a run result each time done rises
  int  run_cnt   = 0;
  bit  prev_done = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      run_cnt   = 0;
      prev_done = 1'b0;
    end else begin
      if (cpu_run) run_cnt++;
      if (!(busy && !cpu_run)) chk("rs1_passthru", rs1_out, cpu_rs1);
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_latency", cyc - e.start_cyc + 1, e.n + NR + 2);
          chk("cpu_run_cycles", run_cnt, e.n);
          chk("cycle_count", cycle_count, e.n);
          chk("write_count", write_count, e.wc);
          chk("error_count", error_count, e.err);
          chk("pass", pass, (e.err == 0) ? 1 : 0);
          chk("first_fail_valid", first_fail_valid, (e.err > 0) ? 1 : 0);
          if (e.err > 0) chk("first_fail_reg", first_fail_reg, e.ffr);
        end
        run_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_cpu_run"}, cpu_run, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, error_count, 0);
    chk({tag, "_ffv"}, first_fail_valid, 0);
    chk({tag, "_ffr"}, first_fail_reg, 0);
    chk({tag, "_cycles"}, cycle_count, 0);
    chk({tag, "_writes"}, write_count, 0);
    chk({tag, "_exp_addr"}, exp_addr, 0);
    chk({tag, "_rs1"}, rs1_out, cpu_rs1);
  endtask

  // One run: fill regfile/ROM, plan writeback traffic, predict the result.
  // rst_at>0 pulses reset in that cycle instead of waiting for done.
  task automatic run_one(input int n, input logic [NR-1:0] mask,
                         input logic [NR-1:0] flip, input bit directed,
                         input bit extra, input int rst_at);
    exp_t          e;
    bit            wen  [128];
    logic [AW-1:0] wreg [128];
    bit            seen;
    for (int i = 0; i < NR; i++) begin
      rf[i]  = $urandom;
      rom[i] = flip[i] ? (rf[i] ^ (32'h1 << $urandom_range(0, 31))) : rf[i];
    end
    for (int k = 0; k < 128; k++) begin
      if (directed) begin
        wen[k]  = (k >= 1 && k <= 7);
        wreg[k] = (k <= 3) ? 5'd0 : 5'd7;
      end else begin
        wen[k]  = ($urandom_range(0, 1) == 1);
        wreg[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(1, NR - 1));
      end
    end
    if (directed) begin
      repeat (2) begin
        @(posedge clock); #1;
        wb_en = 1'b1; wb_reg = 5'd3; wb_data = $urandom;
      end
    end
    e.n = n; e.wc = 0; e.err = 0; e.ffr = 0;
    for (int k = 1; k <= n; k++) if (wen[k] && wreg[k] != 0) e.wc++;
    for (int i = 0; i < NR; i++) begin
      if (mask[i] && flip[i]) begin
        if (e.err == 0) e.ffr = i;
        e.err++;
      end
    end
    @(posedge clock); #1;
    start = 1'b1; num_cycles = CW'(n); compare_mask = mask;
    wb_en = wen[0]; wb_reg = wreg[0]; wb_data = $urandom;
    e.start_cyc = cyc + 1;
    if (rst_at == 0) sb.push_back(e);
    seen = 1'b0;
    for (int k = 1; k <= n + NR + 8 && !seen; k++) begin
      @(posedge clock); #1;
      start   = extra && ((k == 2 && n >= 3) || k == n + 5);
      wb_en   = wen[k]; wb_reg = wreg[k]; wb_data = $urandom;
      cpu_rs1 = AW'($urandom);
      if (rst_at > 0 && k == rst_at) begin
        chk("in_scan_before_reset", busy && !cpu_run, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_zero("scan_reset");
        reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_after_reset", busy, 0);
        seen = 1'b1;
      end else begin
        seen = done;
      end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    start = 1'b0; wb_en = 1'b0;
    @(negedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_cycles = '0; compare_mask = '0;
    cpu_rs1 = 5'd9; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    for (int i = 0; i < NR; i++) begin rf[i] = '0; rom[i] = '0; end
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;

    run_one(10, '1, '0, 1'b0, 1'b0, 0);
    run_one(10, '1, (32'h1 << 5) | (32'h1 << 17), 1'b0, 1'b0, 0);
    run_one(10, ~(32'h1 << 5), (32'h1 << 5) | (32'h1 << 17), 1'b0, 1'b0, 0);
    run_one(0, '1, $urandom & $urandom, 1'b0, 1'b0, 0);
    run_one(10, '1, '0, 1'b1, 1'b0, 0);
    run_one(8, '1, 32'h8000_0001, 1'b0, 1'b1, 0);
    run_one(1, $urandom, $urandom, 1'b0, 1'b1, 0);
    for (int t = 0; t < 12; t++) begin
      run_one($urandom_range(0, 20), $urandom, $urandom & $urandom & $urandom,
              1'b0, ($urandom_range(0, 1) == 1), 0);
    end
    run_one(5, '1, 32'h0000_0100, 1'b0, 1'b0, 15);
    run_one(4, '1, 32'h0000_0100, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/regfile_scan_checker.md
# regfile_scan_checker

Synthesizable self-check engine for the RISC-V processor test system. It runs the CPU for a programmed number of cycles, then stops it. It takes over the regfile's A read port to scan every register against an expected-value ROM, with a per-register compare mask. It reports pass/fail, the error count, the first failing register and the count of committed register writes. It sits between the processor's `ctrl_readRegA` output and the regfile, so on-board and simulated runs can be checked without a testbench file flow.

## Interface
Parameters:
- `NUM_REGS`, 32, registers scanned, indices 0..NUM_REGS-1.
- `REG_ADDR_W`, 5, register index width; 2^REG_ADDR_W >= NUM_REGS.
- `DATA_W`, 32, register and expected-value width.
- `CYCLE_W`, 16, width of the cycle and write counters.
- `ERR_W`, $clog2(NUM_REGS+1), error counter width.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run; sampled in IDLE or DONE only.
- `num_cycles` in CYCLE_W: CPU run length; latched when `start` is accepted.
- `compare_mask` in NUM_REGS: bit i=1 compares register i; latched when `start` is accepted.
- `cpu_run` out 1: CPU clock-enable; high only in RUN.
- `cpu_rs1` in REG_ADDR_W: processor's `ctrl_readRegA`.
- `rs1_out` out REG_ADDR_W: to regfile `ctrl_readRegA`; equals the scan index in SCAN, otherwise `cpu_rs1` (combinational mux).
- `reg_data` in DATA_W: regfile `data_readRegA` (combinational read).
- `exp_addr` out REG_ADDR_W: expected-value ROM address.
- `exp_data` in DATA_W: ROM data; synchronous read, 1-cycle latency.
- `wb_en` in 1, `wb_reg` in REG_ADDR_W, `wb_data` in DATA_W: processor writeback (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`).
- `busy` out 1: high in RUN or SCAN.
- `done` out 1: high in DONE.
- `pass` out 1: high in DONE when `error_count`==0.
- `error_count` out ERR_W.
- `first_fail_reg` out REG_ADDR_W, `first_fail_valid` out 1.
- `cycle_count` out CYCLE_W: RUN cycles elapsed.
- `write_count` out CYCLE_W: writebacks with `wb_reg`!=0 during RUN.

## Operation
- FSM states: IDLE, RUN, SCAN, DONE.
- IDLE → RUN on `start`; if the latched `num_cycles`==0, IDLE → SCAN directly.
- A transition on `start` latches `num_cycles` and `compare_mask`. It also clears `error_count`, `first_fail_*`, `cycle_count`, `write_count` and the scan index.
- RUN: `cpu_run`=1 and `cycle_count`+=1 each cycle.
  - Go to SCAN on the edge where `cycle_count`==N-1, so `cpu_run` is high for exactly N cycles.
- Write monitor, RUN only: `wb_en`=1 and `wb_reg`!=0 increments `write_count`. It saturates at all-ones. Writes outside RUN are ignored.
- SCAN is a two-stage pipeline.
  - Issue stage, index i = 0..NUM_REGS-1: drive `rs1_out`=`exp_addr`=i and register `reg_data` with i.
  - Compare stage, next cycle: if mask[i]=1 and captured data != `exp_data`, increment `error_count`.
  - On the first such mismatch, load `first_fail_reg`=i and set `first_fail_valid`=1; later mismatches do not change them.
  - SCAN lasts NUM_REGS+1 cycles (issue plus drain), then goes to DONE.
- DONE: status holds. `start` → RUN, or → SCAN when N=0.
- `start` in RUN or SCAN is ignored.
- `error_count` cannot overflow: it is at most NUM_REGS.
- `reset` at any time forces IDLE next edge. All outputs and counters go to 0, and `rs1_out` then follows `cpu_rs1`.

## Timing
- Reset values: `cpu_run`=`busy`=`done`=`pass`=`first_fail_valid`=0; `error_count`=`first_fail_reg`=`cycle_count`=`write_count`=`exp_addr`=0.
- Cycle 0 is the edge that samples `start`.
- N>0: `cpu_run` is high in cycles 1..N and SCAN occupies cycles N+1..N+NUM_REGS+1.
- `done` rises at edge N+NUM_REGS+2 after `start`. The same formula holds for N=0.
- `error_count` and `first_fail_*` are final when `done` rises; their values before that are not defined for use.
- `rs1_out` switches to the scan index in the first SCAN cycle. The CPU is already frozen at that point (`cpu_run`=0).

## Test plan
- NUM_REGS=32, N=10, mask all 1s, ROM matches regfile → `pass`=1, `error_count`=0, `done` rises 44 cycles after `start`, `cycle_count`=10.
- Same as the first, but registers 5 and 17 mismatch → `error_count`=2, `first_fail_reg`=5, `first_fail_valid`=1, `pass`=0.
- Same as the second with mask bit 5=0 → `error_count`=1, `first_fail_reg`=17.
- N=0 → `cpu_run` never high, SCAN starts cycle 1, `done` at cycle 34.
- In RUN, 3 writes to x0 and 4 writes to x7; 2 writes while IDLE → `write_count`=4.
- `reset` pulsed during SCAN → next cycle IDLE, all outputs 0, `rs1_out`=`cpu_rs1`. A `start` issued during RUN is ignored: timing is unchanged.
